// File: rtl/floo_vc_rx_buffer.sv
// Receive-side VC input buffer: one show-ahead FIFO per virtual channel, filled by VC id and drained by
// per-VC ready, with one registered credit pulse returned upstream for every flit dequeued.
module floo_vc_rx_buffer #(
    parameter type         flit_t        = logic,
    parameter int unsigned NumVC         = 4,
    parameter int unsigned NumVCWidth    = NumVC > 1 ? $clog2(NumVC) : 1,
    parameter int unsigned NumVCWidthMax = 2,
    parameter int unsigned VCDepth       = 2,
    parameter int unsigned DeeperVCId    = 0,
    parameter int unsigned DeeperVCDepth = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [NumVCWidthMax-1:0] vc_id_i,
    input  flit_t                    data_i,
    output logic [NumVC-1:0]         vc_valid_o,
    output flit_t [NumVC-1:0]        vc_data_o,
    input  logic [NumVC-1:0]         vc_ready_i,
    output logic [NumVC-1:0]         credit_o,
    output logic                     overflow_err_o
);

    logic [NumVC-1:0] push;
    logic [NumVC-1:0] pop;
    logic             drop;

    assign pop = vc_valid_o & vc_ready_i;

    // A valid flit that no FIFO accepted was either aimed at a full VC or at a nonexistent one.
    assign drop = valid_i && (push == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_o       <= '0;
            overflow_err_o <= 1'b0;
        end else begin
            credit_o       <= pop;
            overflow_err_o <= overflow_err_o | drop;
        end
    end

    for (genvar v = 0; v < NumVC; v++) begin : gen_vc
        localparam int unsigned Depth = (v == DeeperVCId) ? DeeperVCDepth : VCDepth;
        localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
        localparam int unsigned CntW  = $clog2(Depth + 1);
        localparam logic [NumVCWidth-1:0] VcIdx = NumVCWidth'(v);

        flit_t            mem [Depth];
        logic [PtrW-1:0]  rptr_q;
        logic [PtrW-1:0]  wptr_q;
        logic [CntW-1:0]  cnt_q;

        assign vc_valid_o[v] = (cnt_q != '0);
        assign vc_data_o[v]  = vc_valid_o[v] ? mem[rptr_q] : '0;

        // A full FIFO still accepts when its head leaves in the same cycle.
        assign push[v] = valid_i && (vc_id_i == NumVCWidthMax'(VcIdx))
                         && ((cnt_q < CntW'(Depth)) || pop[v]);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rptr_q <= '0;
                wptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[v]) begin
                    wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
                end
                if (pop[v]) begin
                    rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
                end
                if (push[v] && !pop[v]) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (pop[v] && !push[v]) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end

        // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
        always_ff @(posedge clk_i) begin
            if (push[v]) begin
                mem[wptr_q] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_floo_vc_rx_buffer.sv
// Directed bench for floo_vc_rx_buffer: a vector table for single-cycle behaviour plus hand-written
// sequences for asynchronous reset, pointer wrap and an out-of-range VC id on a three-VC build.
module tb_floo_vc_rx_buffer;

    typedef logic [7:0] flit_t;

    typedef struct {
        logic        doRst;
        logic        valid;
        logic [1:0]  vc;
        flit_t       data;
        logic [3:0]  ready;
        logic [3:0]  expValid;
        logic [3:0]  expCredit;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             valid;
    logic [1:0]       vcId;
    flit_t            data;
    logic [3:0]       ready;
    logic [3:0]       vcValid;
    flit_t [3:0]      vcData;
    logic [3:0]       credit;
    logic             overflowErr;

    logic             valid2;
    logic [1:0]       vcId2;
    flit_t            data2;
    logic [2:0]       ready2;
    logic [2:0]       vcValid2;
    flit_t [2:0]      vcData2;
    logic [2:0]       credit2;
    logic             overflowErr2;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    floo_vc_rx_buffer #(
        .flit_t(flit_t), .NumVC(4), .NumVCWidthMax(2),
        .VCDepth(2), .DeeperVCId(0), .DeeperVCDepth(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .vc_id_i(vcId), .data_i(data),
        .vc_valid_o(vcValid), .vc_data_o(vcData), .vc_ready_i(ready),
        .credit_o(credit), .overflow_err_o(overflowErr)
    );

    floo_vc_rx_buffer #(
        .flit_t(flit_t), .NumVC(3), .NumVCWidthMax(2),
        .VCDepth(2), .DeeperVCId(0), .DeeperVCDepth(2)
    ) dut3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid2), .vc_id_i(vcId2), .data_i(data2),
        .vc_valid_o(vcValid2), .vc_data_o(vcData2), .vc_ready_i(ready2),
        .credit_o(credit2), .overflow_err_o(overflowErr2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input int unsigned r, input int unsigned v, input int unsigned vc,
                          input int unsigned d, input int unsigned rdy, input int unsigned ev,
                          input int unsigned ec, input int unsigned ee, input int unsigned ed);
        vec_t t;
        t.doRst     = r[0];
        t.valid     = v[0];
        t.vc        = vc[1:0];
        t.data      = d[7:0];
        t.ready     = rdy[3:0];
        t.expValid  = ev[3:0];
        t.expCredit = ec[3:0];
        t.expErr    = ee[0];
        t.expData   = ed;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs at the falling edge and sample just after the following rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] vc,
                                 input flit_t d, input logic [3:0] rdy);
        @(negedge clk);
        rst   = r;
        valid = v;
        vcId  = vc;
        data  = d;
        ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkMain(input string tag, input logic [3:0] ev, input logic [3:0] ec,
                             input logic ee, input logic [31:0] ed);
        checkOutput({tag, " vc_valid"}, 32'(vcValid), 32'(ev));
        checkOutput({tag, " credit"}, 32'(credit), 32'(ec));
        checkOutput({tag, " overflow_err"}, 32'(overflowErr), 32'(ee));
        checkOutput({tag, " vc_data"}, vcData, ed);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; vcId = '0; data = '0; ready = '0;
        valid2 = 1'b0; vcId2 = '0; data2 = '0; ready2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkMain("reset", 4'b0000, 4'b0000, 1'b0, 32'h0);
        checkOutput("reset3 vc_valid", 32'(vcValid2), 32'h0);
        checkOutput("reset3 overflow_err", 32'(overflowErr2), 32'h0);

        // single flit on VC1, popped the cycle it appears
        addVec(0, 1, 1, 'hA1, 'b0000, 'b0010, 'b0000, 0, 'h0000A100);
        addVec(0, 0, 0, 'h00, 'b0010, 'b0000, 'b0010, 0, 'h0);
        addVec(0, 0, 0, 'h00, 'b0000, 'b0000, 'b0000, 0, 'h0);
        // overflow on VC2, then drain in order
        addVec(0, 1, 2, 'hC1, 'b0000, 'b0100, 'b0000, 0, 'h00C10000);
        addVec(0, 1, 2, 'hC2, 'b0000, 'b0100, 'b0000, 0, 'h00C10000);
        addVec(0, 1, 2, 'hC3, 'b0000, 'b0100, 'b0000, 1, 'h00C10000);
        addVec(0, 0, 0, 'h00, 'b0100, 'b0100, 'b0100, 1, 'h00C20000);
        addVec(0, 0, 0, 'h00, 'b0100, 'b0000, 'b0100, 1, 'h0);
        addVec(0, 0, 0, 'h00, 'b0000, 'b0000, 'b0000, 1, 'h0);
        addVec(1, 0, 0, 'h00, 'b0000, 'b0000, 'b0000, 0, 'h0);
        // push onto a full VC2 while its head leaves
        addVec(0, 1, 2, 'hD1, 'b0000, 'b0100, 'b0000, 0, 'h00D10000);
        addVec(0, 1, 2, 'hD2, 'b0000, 'b0100, 'b0000, 0, 'h00D10000);
        addVec(0, 1, 2, 'hD3, 'b0100, 'b0100, 'b0100, 0, 'h00D20000);
        addVec(0, 0, 0, 'h00, 'b0100, 'b0100, 'b0100, 0, 'h00D30000);
        addVec(0, 0, 0, 'h00, 'b0100, 'b0000, 'b0100, 0, 'h0);
        addVec(0, 0, 0, 'h00, 'b0000, 'b0000, 'b0000, 0, 'h0);
        // deeper VC0 takes three, drops the fourth; simultaneous pops on VC0 and VC3
        addVec(0, 1, 0, 'hE1, 'b0000, 'b0001, 'b0000, 0, 'h000000E1);
        addVec(0, 1, 0, 'hE2, 'b0000, 'b0001, 'b0000, 0, 'h000000E1);
        addVec(0, 1, 0, 'hE3, 'b0000, 'b0001, 'b0000, 0, 'h000000E1);
        addVec(0, 1, 3, 'hF1, 'b0000, 'b1001, 'b0000, 0, 'hF10000E1);
        addVec(0, 1, 0, 'hE4, 'b0000, 'b1001, 'b0000, 1, 'hF10000E1);
        addVec(0, 1, 3, 'hF2, 'b0000, 'b1001, 'b0000, 1, 'hF10000E1);
        addVec(0, 0, 0, 'h00, 'b1001, 'b1001, 'b1001, 1, 'hF20000E2);
        addVec(0, 0, 0, 'h00, 'b0001, 'b1001, 'b0001, 1, 'hF20000E3);
        addVec(0, 0, 0, 'h00, 'b0001, 'b1000, 'b0001, 1, 'hF2000000);
        addVec(0, 0, 0, 'h00, 'b0001, 'b1000, 'b0000, 1, 'hF2000000);
        addVec(1, 0, 0, 'h00, 'b0000, 'b0000, 'b0000, 0, 'h0);
        // VC3 at normal depth errors on its third flit
        addVec(0, 1, 3, 'h61, 'b0000, 'b1000, 'b0000, 0, 'h61000000);
        addVec(0, 1, 3, 'h62, 'b0000, 'b1000, 'b0000, 0, 'h61000000);
        addVec(0, 1, 3, 'h63, 'b0000, 'b1000, 'b0000, 1, 'h61000000);
        addVec(0, 0, 0, 'h00, 'b0000, 'b1000, 'b0000, 1, 'h61000000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].doRst, vecs[i].valid, vecs[i].vc, vecs[i].data, vecs[i].ready);
            checkMain($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expCredit,
                      vecs[i].expErr, vecs[i].expData);
        end

        // reset in the middle of a cycle with VC1 holding flits and a credit pending
        applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        applyStimulus(1'b0, 1'b1, 2'd1, 8'h71, 4'b0000);
        applyStimulus(1'b0, 1'b1, 2'd1, 8'h72, 4'b0000);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
        checkMain("prerst", 4'b0010, 4'b0010, 1'b0, 32'h00007200);
        #2 rst = 1'b1;
        #1;
        checkMain("midrst", 4'b0000, 4'b0000, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
            checkMain($sformatf("postrst%0d", i), 4'b0000, 4'b0000, 1'b0, 32'h0);
        end

        // interleaved push/pop on VC1 wraps the pointers; order must stay A..J
        applyStimulus(1'b0, 1'b1, 2'd1, 8'h41, 4'b0000);
        checkOutput("wrap first head", 32'(vcData[1]), 32'h41);
        applyStimulus(1'b0, 1'b1, 2'd1, 8'h42, 4'b0000);
        for (int k = 2; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 8'(8'h41 + k), 4'b0010);
            checkOutput($sformatf("wrap%0d head", k), 32'(vcData[1]), 32'(8'h41 + k - 1));
            checkOutput($sformatf("wrap%0d credit", k), 32'(credit), 32'h2);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
        checkMain("wrap drain1", 4'b0010, 4'b0010, 1'b0, 32'h00004A00);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
        checkMain("wrap drain2", 4'b0000, 4'b0010, 1'b0, 32'h0);

        // three-VC build: id 2 is stored, id 3 does not exist and is dropped
        @(negedge clk);
        valid = 1'b0; ready = '0;
        valid2 = 1'b1; vcId2 = 2'd2; data2 = 8'h55;
        @(posedge clk); #1;
        checkOutput("nvc3 valid", 32'(vcValid2), 32'h4);
        checkOutput("nvc3 data", vcData2, 24'h550000);
        checkOutput("nvc3 err before", 32'(overflowErr2), 32'h0);
        @(negedge clk);
        vcId2 = 2'd3; data2 = 8'h66;
        @(posedge clk); #1;
        checkOutput("nvc3 bad id err", 32'(overflowErr2), 32'h1);
        checkOutput("nvc3 bad id valid", 32'(vcValid2), 32'h4);
        checkOutput("nvc3 bad id data", vcData2, 24'h550000);
        @(negedge clk);
        valid2 = 1'b0;
        @(posedge clk); #1;
        checkOutput("nvc3 err sticky", 32'(overflowErr2), 32'h1);
        checkOutput("nvc3 credit", 32'(credit2), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
